// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
//   Parametrised integer clock divider for UART/peripheral clock generation.
//   Ratio changes and enable removal take effect only at a period boundary,
//   so the divided clock never produces runt pulses. Ratios 0 and 1 bypass
//   the divider and pass the reference clock straight through.
//
// Parameters:
//   DIV_W        width of the ratio input and the period counter
//
// Ports:
//   I_ref_clk    in   reference clock, all logic on its rising edge
//   I_rst        in   synchronous reset, active-high
//   I_clk_en     in   divider enable
//   I_div_ratio  in   requested ratio R (sampled at period boundaries)
//   o_div_clk    out  divided clock (reference clock when bypassed)
//   o_div_tick   out  one-cycle pulse in the last cycle of each period
//   o_busy       out  high while running or bypassing
//   o_act_ratio  out  ratio currently in effect
//   o_phase_cnt  out  registered period counter, only with CLKDIV_PHASE_OUT_EN
//
// Optional build macro:
//   CLKDIV_PHASE_OUT_EN  adds the o_phase_cnt debug/phase output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | stopped, o_div_clk held low, waiting for I_clk_en
// S_RUN   | dividing; counter runs 0..R-1, high for ceil(R/2) cycles
// S_BYPASS| R < 2; o_div_clk follows I_ref_clk through the output mux

module clk_div_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             I_ref_clk,
  input  logic             I_rst,
  input  logic             I_clk_en,
  input  logic [DIV_W-1:0] I_div_ratio,
  output logic             o_div_clk,
  output logic             o_div_tick,
  output logic             o_busy,
`ifdef CLKDIV_PHASE_OUT_EN
  output logic [DIV_W-1:0] o_phase_cnt,
`endif
  output logic [DIV_W-1:0] o_act_ratio
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_BYPASS = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] cnt, cnt_d;
  logic [DIV_W-1:0] act_ratio, act_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             bypass_q, bypass_d;

  logic [DIV_W-1:0] cnt_inc;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W:0]   high_len;
  logic             at_wrap;
  logic             ratio_ge2;

  // high_len is one bit wider so ceil(R/2) cannot overflow at R = 2^DIV_W-1
  assign cnt_inc   = cnt + DIV_W'(1);
  assign last_cnt  = act_ratio - DIV_W'(1);
  assign high_len  = ({1'b0, act_ratio} + (DIV_W+1)'(1)) >> 1;
  assign at_wrap   = (cnt == last_cnt);
  assign ratio_ge2 = (I_div_ratio >= DIV_W'(2));

  always_ff @(posedge I_ref_clk) begin
    if (I_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
      act_ratio <= '0;
      bypass_q  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      act_ratio <= act_d;
      bypass_q  <= bypass_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    div_d    = div_q;
    tick_d   = 1'b0;
    act_d    = act_ratio;
    bypass_d = bypass_q;

    unique case (state)
      S_IDLE: begin
        cnt_d    = '0;
        div_d    = 1'b0;
        bypass_d = 1'b0;
        if (I_clk_en) begin
          act_d = I_div_ratio;
          if (ratio_ge2) begin
            div_d   = 1'b1;
            state_d = S_RUN;
          end else begin
            bypass_d = 1'b1;
            state_d  = S_BYPASS;
          end
        end
      end

      S_RUN: begin
        if (at_wrap) begin
          // Only the boundary edge may stop the divider or change its ratio.
          cnt_d = '0;
          if (!I_clk_en) begin
            div_d   = 1'b0;
            state_d = S_IDLE;
          end else if (ratio_ge2) begin
            act_d = I_div_ratio;
            div_d = 1'b1;
          end else begin
            act_d    = I_div_ratio;
            div_d    = 1'b0;
            bypass_d = 1'b1;
            state_d  = S_BYPASS;
          end
        end else begin
          cnt_d  = cnt_inc;
          div_d  = ({1'b0, cnt_inc} < high_len);
          tick_d = (cnt_inc == last_cnt);
        end
      end

      S_BYPASS: begin
        cnt_d = '0;
        div_d = 1'b0;
        if (!I_clk_en) begin
          bypass_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          act_d = I_div_ratio;
          if (ratio_ge2) begin
            // div_q rises on the same edge bypass_q falls: output stays high.
            div_d    = 1'b1;
            bypass_d = 1'b0;
            state_d  = S_RUN;
          end
        end
      end

      default: begin
        cnt_d    = '0;
        div_d    = 1'b0;
        bypass_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // Realised as a clock-mux cell in the backend; select is registered.
  assign o_div_clk   = bypass_q ? I_ref_clk : div_q;
  assign o_div_tick  = tick_q;
  assign o_busy      = (state != S_IDLE);
  assign o_act_ratio = act_ratio;

`ifdef CLKDIV_PHASE_OUT_EN
  assign o_phase_cnt = cnt;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       ref_clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic       div_clk;
  logic       div_tick;
  logic       busy;
  logic [7:0] act_ratio;
`ifdef CLKDIV_PHASE_OUT_EN
  logic [7:0] phase_cnt;
`endif

  clk_div_ctrl #(.DIV_W(8)) dut (
    .I_ref_clk   (ref_clk),
    .I_rst       (rst),
    .I_clk_en    (clk_en),
    .I_div_ratio (div_ratio),
    .o_div_clk   (div_clk),
    .o_div_tick  (div_tick),
    .o_busy      (busy),
`ifdef CLKDIV_PHASE_OUT_EN
    .o_phase_cnt (phase_cnt),
`endif
    .o_act_ratio (act_ratio)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    logic       hi;
    logic       lo;
    logic       tick;
    logic       busy;
    logic [7:0] act;
    logic [7:0] ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   vec    = 0;
  logic done   = 1'b0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", nm, vec, got, exp);
  endtask

  // One vector = inputs applied before the next rising edge plus the
  // outputs expected after it. byp=1 means o_div_clk must follow ref_clk.
  task automatic c(input logic r, input logic en, input logic [7:0] ratio,
                   input logic hi, input logic tick, input logic bsy,
                   input logic [7:0] act, input logic [7:0] ph, input logic byp);
    exp_t e;
    @(negedge ref_clk);
    rst       = r;
    clk_en    = en;
    div_ratio = ratio;
    e.hi   = byp ? 1'b1 : hi;
    e.lo   = byp ? 1'b0 : hi;
    e.tick = tick;
    e.busy = bsy;
    e.act  = act;
    e.ph   = ph;
    q.push_back(e);
  endtask

  // Monitor: samples with ref_clk high and again with it low.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge ref_clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        vec++;
        chk("div_clk_hi", {7'd0, div_clk}, {7'd0, e.hi});
        chk("div_tick",   {7'd0, div_tick}, {7'd0, e.tick});
        chk("busy",       {7'd0, busy}, {7'd0, e.busy});
        chk("act_ratio",  act_ratio, e.act);
`ifdef CLKDIV_PHASE_OUT_EN
        chk("phase_cnt",  phase_cnt, e.ph);
`endif
        @(negedge ref_clk);
        #2;
        chk("div_clk_lo", {7'd0, div_clk}, {7'd0, e.lo});
      end
    end
  end

  initial begin
    int wait_cyc;
    // reset, then reset held together with enable (reset wins)
    c(1, 0, 0,   0, 0, 0, 0, 0, 0);
    c(1, 1, 4,   0, 0, 0, 0, 0, 0);
    // 1: R=4, 2 high / 2 low, tick on last low cycle
    c(0, 1, 4,   1, 0, 1, 4, 0, 0);
    c(0, 1, 4,   1, 0, 1, 4, 1, 0);
    c(0, 1, 4,   0, 0, 1, 4, 2, 0);
    c(0, 1, 4,   0, 1, 1, 4, 3, 0);
    c(0, 1, 4,   1, 0, 1, 4, 0, 0);
    c(0, 1, 4,   1, 0, 1, 4, 1, 0);
    c(0, 1, 4,   0, 0, 1, 4, 2, 0);
    c(0, 1, 4,   0, 1, 1, 4, 3, 0);
    // 2: R=5 loaded at wrap; ratio 3 requested mid-period is deferred
    c(0, 1, 5,   1, 0, 1, 5, 0, 0);
    c(0, 1, 5,   1, 0, 1, 5, 1, 0);
    c(0, 1, 3,   1, 0, 1, 5, 2, 0);
    c(0, 1, 3,   0, 0, 1, 5, 3, 0);
    c(0, 1, 3,   0, 1, 1, 5, 4, 0);
    c(0, 1, 3,   1, 0, 1, 3, 0, 0);
    c(0, 1, 3,   1, 0, 1, 3, 1, 0);
    c(0, 1, 3,   0, 1, 1, 3, 2, 0);
    c(0, 1, 3,   1, 0, 1, 3, 0, 0);
    c(0, 1, 3,   1, 0, 1, 3, 1, 0);
    c(0, 1, 3,   0, 1, 1, 3, 2, 0);
    // 3: R=6, enable dropped in high phase; period completes, then idle
    c(0, 1, 6,   1, 0, 1, 6, 0, 0);
    c(0, 1, 6,   1, 0, 1, 6, 1, 0);
    c(0, 0, 6,   1, 0, 1, 6, 2, 0);
    c(0, 0, 6,   0, 0, 1, 6, 3, 0);
    c(0, 0, 6,   0, 0, 1, 6, 4, 0);
    c(0, 0, 6,   0, 1, 1, 6, 5, 0);
    c(0, 0, 6,   0, 0, 0, 6, 0, 0);
    c(0, 0, 6,   0, 0, 0, 6, 0, 0);
    // 4: bypass with R=1 then R=0, then switch to R=2
    c(0, 1, 1,   0, 0, 1, 1, 0, 1);
    c(0, 1, 1,   0, 0, 1, 1, 0, 1);
    c(0, 1, 0,   0, 0, 1, 0, 0, 1);
    c(0, 1, 0,   0, 0, 1, 0, 0, 1);
    c(0, 1, 2,   1, 0, 1, 2, 0, 0);
    c(0, 1, 2,   0, 1, 1, 2, 1, 0);
    c(0, 1, 2,   1, 0, 1, 2, 0, 0);
    c(0, 1, 2,   0, 1, 1, 2, 1, 0);
    // RUN -> BYPASS at wrap, then disable from bypass
    c(0, 1, 1,   0, 0, 1, 1, 0, 1);
    c(0, 0, 1,   0, 0, 0, 1, 0, 0);
    // 5: R=255, 128 high / 127 low, single tick per period
    c(0, 1, 255, 1, 0, 1, 255, 0, 0);
    for (int k = 1; k <= 254; k++)
      c(0, 1, 255, (k < 128), (k == 254), 1, 255, 8'(k), 0);
    c(0, 1, 255, 1, 0, 1, 255, 0, 0);
    for (int k = 1; k <= 50; k++)
      c(0, 1, 255, 1, 0, 1, 255, 8'(k), 0);
    // reset mid high phase (enable still high): everything cleared at once
    c(1, 1, 255, 0, 0, 0, 0, 0, 0);
    c(0, 0, 255, 0, 0, 0, 0, 0, 0);
    c(0, 0, 0,   0, 0, 0, 0, 0, 0);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge ref_clk);
      wait_cyc++;
    end
    repeat (2) @(negedge ref_clk);
    chk("queue_drained", 8'(q.size()), 8'd0);
    done = 1'b1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
